dsram_slave_port: RTL and testbench

DSRAM_SLAVE_PORT -- requirements
Module: dsram_slave_port

---
 rtl/dsram_slave_port.sv | 102 ++++++++++
 tb/tb_dsram_slave_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_slave_port.sv
// Single-port data SRAM slave: request/addr_ok acceptance, byte-strobe writes,
// fixed-latency in-order responses with a bounded number of outstanding requests.
module dsram_slave_port #(
   parameter int ADDR_WIDTH      = 12,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  accept;
   logic [31:0]           resp_word;
   logic [CNT_W-1:0]      outstanding;

   // Response pipeline: stage LATENCY-1 drives data_ok/rdata directly.
   logic [LATENCY-1:0]    pipe_v;
   logic [LATENCY-1:0]    pipe_v_in;
   logic [31:0]           pipe_d    [LATENCY];
   logic [31:0]           pipe_d_in [LATENCY];

   logic                  unused_ok;

   assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

   assign word_idx  = data_sram_addr[ADDR_WIDTH+1:2];
   assign resp_word = data_sram_wr ? 32'h0 : mem[word_idx];

   // The response leaving this cycle frees its slot now, so a full port can
   // take a new request in the same cycle as the data_ok.
   assign data_sram_addr_ok = !reset &&
                              ((outstanding < CNT_W'(MAX_OUTSTANDING)) || pipe_v[LATENCY-1]);
   assign accept            = data_sram_req && data_sram_addr_ok;

   assign data_sram_data_ok = pipe_v[LATENCY-1];
   assign data_sram_rdata   = pipe_d[LATENCY-1];

   // NOTE: memory has no reset branch; contents survive reset and a reset on a
   // RAM array would prevent it from mapping onto block memory.
   always_ff @(posedge clk) begin
      if (accept && data_sram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (data_sram_wstrb[b]) begin
               mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
         end
      end
   end

   assign pipe_v_in = LATENCY'({pipe_v, accept});

   always_comb begin
      pipe_d_in[0] = resp_word;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_d_in[i] = pipe_d[i-1];
      end
   end

   // Data only moves with a valid token, so the last stage holds rdata between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i] <= 32'h0;
         end
      end else begin
         pipe_v <= pipe_v_in;
         for (int i = 0; i < LATENCY; i++) begin
            if (pipe_v_in[i]) begin
               pipe_d[i] <= pipe_d_in[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         case ({accept, data_sram_data_ok})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_dsram_slave_port.sv
// Directed bench for dsram_slave_port: default, LATENCY=1 and LATENCY=4/MAX=2
// instances share the request bus; sel picks which one sees req.
module tb_dsram_slave_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   int          sel;

   logic        aok0, dok0, aok1, dok1, aok2, dok2;
   logic [31:0] rd0, rd1, rd2;
   logic        addr_ok_s, data_ok_s;
   logic [31:0] rdata_s;

   int n_cmp;
   int n_bad;

   always #5 clk = ~clk;

   dsram_slave_port u_dut_def (
      .clk(clk), .reset(reset),
      .data_sram_req(req && sel == 0), .data_sram_wr(wr), .data_sram_size(size),
      .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_addr_ok(aok0), .data_sram_data_ok(dok0), .data_sram_rdata(rd0)
   );

   dsram_slave_port #(.LATENCY(1), .MAX_OUTSTANDING(2)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .data_sram_req(req && sel == 1), .data_sram_wr(wr), .data_sram_size(size),
      .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_addr_ok(aok1), .data_sram_data_ok(dok1), .data_sram_rdata(rd1)
   );

   dsram_slave_port #(.LATENCY(4), .MAX_OUTSTANDING(2)) u_dut_l4 (
      .clk(clk), .reset(reset),
      .data_sram_req(req && sel == 2), .data_sram_wr(wr), .data_sram_size(size),
      .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_addr_ok(aok2), .data_sram_data_ok(dok2), .data_sram_rdata(rd2)
   );

   assign addr_ok_s = (sel == 0) ? aok0 : (sel == 1) ? aok1 : aok2;
   assign data_ok_s = (sel == 0) ? dok0 : (sel == 1) ? dok1 : dok2;
   assign rdata_s   = (sel == 0) ? rd0  : (sel == 1) ? rd1  : rd2;

   // One request on the selected instance; returns latency and the response word.
   // Called #1 after a rising edge; returns #1 after the edge ending the data_ok cycle.
   task automatic single_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int lat, output logic [31:0] rdv);
      wr = w; addr = a; wdata = d; wstrb = s; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      lat = 1;
      while (data_ok_s !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdv = rdata_s;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (aok0 !== 1'b0) begin n_bad++; $display("FAIL reset_addr_ok: got %b want 0", aok0); end
      n_cmp++; if (dok0 !== 1'b0) begin n_bad++; $display("FAIL reset_data_ok: got %b want 0", dok0); end
      n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 00000000", rd0); end
      n_cmp++; if (aok2 !== 1'b0) begin n_bad++; $display("FAIL reset_addr_ok_l4: got %b want 0", aok2); end
      reset = 1'b0;
      #1;
      n_cmp++; if ({aok0, aok1, aok2} !== 3'b111) begin
         n_bad++; $display("FAIL post_reset_addr_ok: got %b want 111", {aok0, aok1, aok2});
      end
   endtask

   task automatic test_defaults;
      int          lat;
      logic [31:0] r;
      sel = 0;
      @(posedge clk); #1;
      single_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, r);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL def_write_latency: got %0d want 2", lat); end
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL def_write_rdata: got %h want 00000000", r); end
      single_req(1'b0, 32'h10, 32'h0, 4'h0, lat, r);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL def_read_latency: got %0d want 2", lat); end
      n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL def_read_rdata: got %h want deadbeef", r); end
      n_cmp++; if (data_ok_s !== 1'b0 || rdata_s !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL def_rdata_hold: got ok=%b data=%h want ok=0 data=deadbeef", data_ok_s, rdata_s);
      end
   endtask

   task automatic test_byte_strobes;
      int          lat;
      logic [31:0] r;
      sel = 0;
      single_req(1'b1, 32'h20, 32'h11223344, 4'hF, lat, r);
      single_req(1'b1, 32'h21, 32'h0000AA00, 4'h2, lat, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL strb_write_rdata: got %h want 00000000", r); end
      single_req(1'b0, 32'h23, 32'h0, 4'h0, lat, r);
      n_cmp++; if (r !== 32'h1122AA44) begin n_bad++; $display("FAIL strb_read: got %h want 1122aa44", r); end
      single_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, r);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL strb0_latency: got %0d want 2", lat); end
      single_req(1'b0, 32'h0000_4020, 32'h0, 4'h0, lat, r);
      n_cmp++; if (r !== 32'h1122AA44) begin n_bad++; $display("FAIL strb0_alias_read: got %h want 1122aa44", r); end
   endtask

   task automatic test_back_to_back;
      sel = 1;
      req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'h5; wstrb = 4'hF;
      @(posedge clk); #1;
      wr = 1'b0;
      n_cmp++; if (data_ok_s !== 1'b1 || rdata_s !== 32'h0) begin
         n_bad++; $display("FAIL b2b_l1_first: got ok=%b data=%h want ok=1 data=00000000", data_ok_s, rdata_s);
      end
      @(posedge clk); #1;
      req = 1'b0;
      n_cmp++; if (data_ok_s !== 1'b1 || rdata_s !== 32'h5) begin
         n_bad++; $display("FAIL b2b_l1_second: got ok=%b data=%h want ok=1 data=00000005", data_ok_s, rdata_s);
      end
      @(posedge clk); #1;
      n_cmp++; if (data_ok_s !== 1'b0 || rdata_s !== 32'h5) begin
         n_bad++; $display("FAIL b2b_l1_after: got ok=%b data=%h want ok=0 data=00000005", data_ok_s, rdata_s);
      end

      sel = 0;
      req = 1'b1; wr = 1'b0; addr = 32'h10;
      @(posedge clk); #1;
      addr = 32'h20;
      @(posedge clk); #1;
      req = 1'b0;
      n_cmp++; if (data_ok_s !== 1'b1 || rdata_s !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL b2b_def_first: got ok=%b data=%h want ok=1 data=deadbeef", data_ok_s, rdata_s);
      end
      @(posedge clk); #1;
      n_cmp++; if (data_ok_s !== 1'b1 || rdata_s !== 32'h1122AA44) begin
         n_bad++; $display("FAIL b2b_def_second: got ok=%b data=%h want ok=1 data=1122aa44", data_ok_s, rdata_s);
      end
      @(posedge clk); #1;
      n_cmp++; if (data_ok_s !== 1'b0) begin n_bad++; $display("FAIL b2b_def_extra: got ok=%b want 0", data_ok_s); end
   endtask

   task automatic test_outstanding;
      int          lat;
      logic [31:0] r;
      logic [15:0] aok_v;
      logic [15:0] dok_v;
      int          rd_bad;
      sel = 2;
      single_req(1'b1, 32'h60, 32'hA5A50001, 4'hF, lat, r);
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL l4_write_latency: got %0d want 4", lat); end
      rd_bad = 0;
      wr = 1'b0; addr = 32'h60; req = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 12) req = 1'b0;
         aok_v[k] = addr_ok_s;
         dok_v[k] = data_ok_s;
         if (data_ok_s === 1'b1 && rdata_s !== 32'hA5A50001) rd_bad++;
         @(posedge clk); #1;
      end
      n_cmp++; if (aok_v !== 16'hF333) begin n_bad++; $display("FAIL limit_addr_ok_trace: got %h want f333", aok_v); end
      n_cmp++; if (dok_v !== 16'h3330) begin n_bad++; $display("FAIL limit_data_ok_trace: got %h want 3330", dok_v); end
      n_cmp++; if (rd_bad != 0) begin n_bad++; $display("FAIL limit_rdata: got %0d bad words want 0", rd_bad); end
   endtask

   task automatic test_gating;
      int          lat;
      logic [31:0] r;
      int          n_ok;
      sel = 2;
      single_req(1'b1, 32'h50, 32'h12345678, 4'hF, lat, r);
      req = 1'b1; wr = 1'b0; addr = 32'h60;
      @(posedge clk); #1;
      @(posedge clk); #1;
      wr = 1'b1; addr = 32'h50; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
      n_cmp++; if (addr_ok_s !== 1'b0) begin n_bad++; $display("FAIL gate_addr_ok_c2: got %b want 0", addr_ok_s); end
      @(posedge clk); #1;
      n_cmp++; if (addr_ok_s !== 1'b0) begin n_bad++; $display("FAIL gate_addr_ok_c3: got %b want 0", addr_ok_s); end
      @(posedge clk); #1;
      req = 1'b0;
      n_ok = 0;
      for (int k = 0; k < 10; k++) begin
         if (data_ok_s === 1'b1) n_ok++;
         @(posedge clk); #1;
      end
      n_cmp++; if (n_ok != 2) begin n_bad++; $display("FAIL gate_data_ok_count: got %0d want 2", n_ok); end
      single_req(1'b0, 32'h50, 32'h0, 4'h0, lat, r);
      n_cmp++; if (r !== 32'h12345678) begin n_bad++; $display("FAIL gate_mem_unchanged: got %h want 12345678", r); end
   endtask

   task automatic test_reset_midflight;
      int          lat;
      logic [31:0] r;
      int          n_ok;
      sel = 2;
      req = 1'b1; wr = 1'b0; addr = 32'h60;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (addr_ok_s !== 1'b0 || data_ok_s !== 1'b0 || rdata_s !== 32'h0) begin
         n_bad++; $display("FAIL midreset_outputs: got aok=%b ok=%b data=%h want 0 0 00000000",
                           addr_ok_s, data_ok_s, rdata_s);
      end
      reset = 1'b0;
      #1;
      n_cmp++; if (addr_ok_s !== 1'b1) begin n_bad++; $display("FAIL midreset_addr_ok: got %b want 1", addr_ok_s); end
      n_ok = 0;
      for (int k = 0; k < 10; k++) begin
         if (dok0 === 1'b1 || dok1 === 1'b1 || dok2 === 1'b1) n_ok++;
         @(posedge clk); #1;
      end
      n_cmp++; if (n_ok != 0) begin n_bad++; $display("FAIL midreset_stray_data_ok: got %0d want 0", n_ok); end
      single_req(1'b0, 32'h60, 32'h0, 4'h0, lat, r);
      n_cmp++; if (r !== 32'hA5A50001) begin n_bad++; $display("FAIL midreset_mem_l4: got %h want a5a50001", r); end
      sel = 0;
      single_req(1'b0, 32'h10, 32'h0, 4'h0, lat, r);
      n_cmp++; if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL midreset_mem_def: got %h want deadbeef", r); end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0;
      addr = 32'h0; wdata = 32'h0; sel = 0;
      n_cmp = 0; n_bad = 0;
      test_reset;
      test_defaults;
      test_byte_strobes;
      test_back_to_back;
      test_outstanding;
      test_gating;
      test_reset_midflight;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
